helper_nvm_writer: RTL and testbench
====================================

Name: helper_nvm_writer

Overview:
- Sits directly downstream of the key-generation top level and consumes its helper_data / helper_data_valid outputs.
- On each new valid helper-data vector it snapshots the vector and frames it as magic word + FE_BLOCKS data words + checksum.
- Writes the frame word-by-word into external NVM over a req/ack handshake, with bounded retry and timeout.

Parameters:
- FE_BLOCKS, 22, number of 32-bit helper words (704 bits).
- NVM_AW, 8, NVM word-address width.
- BASE_ADDR, 0, NVM word address of the frame's magic word.
- MAGIC, 32'h48445A01, frame header word.
- MAX_RETRY, 3, retries per word after nvm_err before failing.
- ACK_TIMEOUT, 255, cycles to wait for nvm_ack per attempt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- helper_data  in  FE_BLOCKS*32  helper vector; block i = bits [32i+31:32i]
- helper_data_valid  in  1  level; rising edge means new helper data
- store_en  in  1  arm; edges seen while low are ignored
- nvm_req  out  1  write request
- nvm_addr  out  NVM_AW  word address
- nvm_wdata  out  32  write data
- nvm_ack  in  1  write accepted/complete (sampled while nvm_req=1)
- nvm_err  in  1  qualified by nvm_ack; write failed
- busy  out  1  frame in progress
- stored  out  1  sticky: last frame written successfully
- error  out  1  sticky: last frame aborted
- fail_idx  out  $clog2(FE_BLOCKS+2)  word index of the failing word

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. nvm_req, busy, stored, error, nvm_addr, nvm_wdata and fail_idx all 0. Edge detector valid_q=0.
- Reset mid-frame: nvm_req drops on that same edge and the partial frame is abandoned. No status is set.
- Trigger: valid_q holds helper_data_valid delayed one cycle. trig = helper_data_valid & ~valid_q & store_en & (state==IDLE).
- On trig: in the same edge, snapshot helper_data into the shadow register, clear stored/error, set busy=1, set widx=0, and seed the checksum with MAGIC. Go to REQ.
- A rising edge arriving while busy is dropped, not queued. The shadow register is not updated during a frame.
- Frame layout (N = FE_BLOCKS+2 words):
  - widx 0 = MAGIC.
  - widx 1..FE_BLOCKS = shadow block widx-1.
  - widx N-1 = checksum: mod-2^32 sum of words 0..N-2.
  - nvm_addr = BASE_ADDR + widx (truncated to NVM_AW).
- States:
  - IDLE: wait for trig.
  - REQ: nvm_req=1; nvm_addr and nvm_wdata stable. Increment tcnt each cycle.
    - nvm_ack & ~nvm_err: accumulate the checksum (skip on the last word). Then go to DONE if widx==N-1, otherwise widx++ and go to GAP.
    - nvm_ack & nvm_err, or tcnt==ACK_TIMEOUT: if rcnt<MAX_RETRY, rcnt++ and go to GAP (same widx). Otherwise fail_idx=widx and go to ERROR.
  - GAP: nvm_req=0 for exactly one cycle; tcnt=0. Return to REQ (rcnt resets only when widx advances).
  - DONE: stored=1, busy=0, go to IDLE.
  - ERROR: error=1, busy=0, go to IDLE.
- nvm_req is registered. It deasserts on the edge where ack is sampled, so each word gets one accepted write.
- nvm_ack outside REQ is ignored.
- Latency with zero-wait NVM (ack in first REQ cycle): 2 cycles per word. busy spans 2N cycles; stored rises 2N cycles after the trig edge (48 for N=24).
- Simultaneous ack and timeout in the same cycle: ack wins.

Decomposition:
- Shared package holds:
  - FE_BLOCKS, MAGIC and frame length N.
  - State encoding (IDLE, REQ, GAP, DONE, ERROR, 3 bits).
  - Word-index width function.
- One natural sub-module: helper_frame_mux. It is combinational word select (magic / shadow block / checksum) from widx and keeps the serializer FSM clean.

Test Plan:
- Clean store: helper_data block i = 32'h1000_0000+i, store_en=1, raise valid, ack every REQ cycle.
  - 24 writes at addr 0..23; word0=48445A01; word23 = sum mod 2^32.
  - stored=1 at trig+48, error=0.
- Wait states: ack delayed 5 cycles per word.
  - addr/wdata stable through each REQ; exactly 24 accepted writes; one-cycle gaps observed.
- Retry: nvm_err with ack on word 5, first two attempts.
  - Word 5 is written 3 times; frame completes; stored=1.
  - With 4 errors on word 5: error=1, fail_idx=5, no writes past addr 5.
- Timeout: never ack.
  - Each attempt lasts ACK_TIMEOUT+1 cycles; 4 attempts on word 0, then error=1, fail_idx=0.
- Gating: toggle valid with store_en=0, then toggle valid again while busy.
  - No request in the first case; the second edge is ignored and the frame data equals the first snapshot.
- Reset mid-frame: rst_n=0 during word 10.
  - nvm_req=0 next edge, all outputs 0; a new trig starts again from addr 0.

Source files
------------

// File: rtl/helper_nvm_writer_pkg.sv
// Shared constants and types for the helper-data NVM writer.
// Frame = magic word, FE_BLOCKS helper words, then a mod-2^32 checksum word.
package helper_nvm_writer_pkg;

    localparam int          HND_FE_BLOCKS = 22;
    localparam logic [31:0] HND_MAGIC     = 32'h48445A01;
    localparam int          HND_FRAME_N   = HND_FE_BLOCKS + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } hnd_state_e;

    // Bits needed to index every word of a frame_n-word frame.
    function automatic int hnd_widx_w(input int frame_n);
        return (frame_n > 2) ? $clog2(frame_n) : 1;
    endfunction

endpackage

// File: rtl/helper_nvm_writer_frame_mux.sv
// Selects the frame word for a word index: magic, shadowed helper block or checksum.
module helper_frame_mux #(
    parameter int          FE_BLOCKS = 22,
    parameter int          WIDX_W    = 5,
    parameter logic [31:0] MAGIC     = 32'h48445A01
) (
    input  logic [WIDX_W-1:0]       widx_i,
    input  logic [FE_BLOCKS*32-1:0] shadow_i,
    input  logic [31:0]             csum_i,
    output logic [31:0]             word_o
);

    always_comb begin
        word_o = MAGIC;
        if (widx_i == WIDX_W'(FE_BLOCKS + 1)) begin
            word_o = csum_i;
        end else begin
            for (int i = 0; i < FE_BLOCKS; i++) begin
                if (int'(widx_i) == i + 1) begin
                    word_o = shadow_i[32*i +: 32];
                end
            end
        end
    end

endmodule

// File: rtl/helper_nvm_writer.sv
// Snapshots each new helper-data vector and writes it to NVM as a framed,
// checksummed sequence of words over a req/ack handshake with retry and timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a rising edge of helper_data_valid while armed
// REQ      | nvm_req high, addr/wdata held, counting towards ack timeout
// GAP      | one-cycle request-low gap; loads addr/wdata for next attempt
// DONE     | frame written; sets stored, clears busy
// ERROR    | retries exhausted; sets error, clears busy
module helper_nvm_writer
    import helper_nvm_writer_pkg::*;
#(
    parameter int          FE_BLOCKS   = HND_FE_BLOCKS,
    parameter int          NVM_AW      = 8,
    parameter int          BASE_ADDR   = 0,
    parameter logic [31:0] MAGIC       = HND_MAGIC,
    parameter int          MAX_RETRY   = 3,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FE_BLOCKS*32-1:0]           helper_data,
    input  logic                              helper_data_valid,
    input  logic                              store_en,
    output logic                              nvm_req,
    output logic [NVM_AW-1:0]                 nvm_addr,
    output logic [31:0]                       nvm_wdata,
    input  logic                              nvm_ack,
    input  logic                              nvm_err,
    output logic                              busy,
    output logic                              stored,
    output logic                              error,
    output logic [$clog2(FE_BLOCKS+2)-1:0]    fail_idx
);

    localparam int FRAME_N = FE_BLOCKS + 2;
    localparam int WIDX_W  = hnd_widx_w(FRAME_N);
    localparam int FI_W    = $clog2(FE_BLOCKS + 2);
    localparam int TC_W    = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RC_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(FRAME_N - 1);

    hnd_state_e               state_q;
    logic                     valid_q;
    logic [FE_BLOCKS*32-1:0]  shadow_q;
    logic [WIDX_W-1:0]        widx_q;
    logic [TC_W-1:0]          tcnt_q;
    logic [RC_W-1:0]          rcnt_q;
    logic [31:0]              csum_q;
    logic                     req_q;
    logic [NVM_AW-1:0]        addr_q;
    logic [31:0]              wdata_q;
    logic                     busy_q;
    logic                     stored_q;
    logic                     error_q;
    logic [FI_W-1:0]          fail_q;

    logic                     trig;
    logic [31:0]              word_d;
    logic [NVM_AW-1:0]        addr_d;

    assign trig   = helper_data_valid & ~valid_q & store_en & (state_q == ST_IDLE);
    assign addr_d = NVM_AW'(BASE_ADDR) + NVM_AW'(widx_q);

    helper_frame_mux #(
        .FE_BLOCKS (FE_BLOCKS),
        .WIDX_W    (WIDX_W),
        .MAGIC     (MAGIC)
    ) u_frame_mux (
        .widx_i   (widx_q),
        .shadow_i (shadow_q),
        .csum_i   (csum_q),
        .word_o   (word_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            shadow_q <= '0;
            widx_q   <= '0;
            tcnt_q   <= '0;
            rcnt_q   <= '0;
            csum_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            stored_q <= 1'b0;
            error_q  <= 1'b0;
            fail_q   <= '0;
        end else begin
            valid_q <= helper_data_valid;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        shadow_q <= helper_data;
                        stored_q <= 1'b0;
                        error_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        widx_q   <= '0;
                        tcnt_q   <= '0;
                        rcnt_q   <= '0;
                        csum_q   <= MAGIC;
                        req_q    <= 1'b1;
                        addr_q   <= NVM_AW'(BASE_ADDR);
                        wdata_q  <= MAGIC;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    tcnt_q <= tcnt_q + TC_W'(1);
                    // ack is checked before timeout so a late ack still counts
                    if (nvm_ack && !nvm_err) begin
                        req_q <= 1'b0;
                        if (widx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            // magic already seeds the sum, so only data words accumulate
                            if (widx_q != '0) begin
                                csum_q <= csum_q + wdata_q;
                            end
                            widx_q  <= widx_q + WIDX_W'(1);
                            rcnt_q  <= '0;
                            state_q <= ST_GAP;
                        end
                    end else if (nvm_ack || (tcnt_q == TC_W'(ACK_TIMEOUT))) begin
                        req_q <= 1'b0;
                        if (rcnt_q < RC_W'(MAX_RETRY)) begin
                            rcnt_q  <= rcnt_q + RC_W'(1);
                            state_q <= ST_GAP;
                        end else begin
                            fail_q  <= FI_W'(widx_q);
                            state_q <= ST_ERROR;
                        end
                    end
                end
                ST_GAP: begin
                    tcnt_q  <= '0;
                    req_q   <= 1'b1;
                    addr_q  <= addr_d;
                    wdata_q <= word_d;
                    state_q <= ST_REQ;
                end
                ST_DONE: begin
                    stored_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_ERROR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign nvm_req   = req_q;
    assign nvm_addr  = addr_q;
    assign nvm_wdata = wdata_q;
    assign busy      = busy_q;
    assign stored    = stored_q;
    assign error     = error_q;
    assign fail_idx  = fail_q;

endmodule

// File: tb/tb_helper_nvm_writer.sv
// Self-checking bench for helper_nvm_writer: NVM responder model plus a write scoreboard.
module tb_helper_nvm_writer;
    import helper_nvm_writer_pkg::*;

    localparam int          FE      = HND_FE_BLOCKS;
    localparam int          N       = HND_FRAME_N;
    localparam logic [31:0] MAGIC_W = 32'h48445A01;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FE*32-1:0]  helper_data = '0;
    logic              helper_data_valid = 1'b0;
    logic              store_en = 1'b0;
    logic              nvm_req;
    logic [7:0]        nvm_addr;
    logic [31:0]       nvm_wdata;
    logic              nvm_ack = 1'b0;
    logic              nvm_err = 1'b0;
    logic              busy;
    logic              stored;
    logic              error;
    logic [4:0]        fail_idx;

    always #5 clk = ~clk;

    helper_nvm_writer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .helper_data       (helper_data),
        .helper_data_valid (helper_data_valid),
        .store_en          (store_en),
        .nvm_req           (nvm_req),
        .nvm_addr          (nvm_addr),
        .nvm_wdata         (nvm_wdata),
        .nvm_ack           (nvm_ack),
        .nvm_err           (nvm_err),
        .busy              (busy),
        .stored            (stored),
        .error             (error),
        .fail_idx          (fail_idx)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t sb[$];

    // responder controls
    int ack_delay = 0;
    bit never_ack = 1'b0;
    int err_addr  = -1;
    int err_limit = 0;
    int err_given = 0;

    // monitor state
    bit          in_req = 1'b0;
    int          cyc = 0;
    logic [7:0]  att_a;
    logic [31:0] att_d;
    int att_in_frame = 0, gap_len = 0, gap_bad = 0, stab_bad = 0;
    int accepted = 0, max_addr = 0;
    int wr_cnt[256];
    int att_len[$];

    // NVM model: decides ack/err at negedge for the following posedge
    always @(negedge clk) begin
        wr_t e;
        if (!nvm_req) begin
            if (in_req) att_len.push_back(cyc + 1);
            in_req  = 1'b0;
            nvm_ack = 1'b0;
            nvm_err = 1'b0;
            if (busy) gap_len++;
        end else begin
            if (!in_req) begin
                if (gap_len != ((att_in_frame == 0) ? 0 : 1)) gap_bad++;
                in_req = 1'b1;
                cyc    = 0;
                att_a  = nvm_addr;
                att_d  = nvm_wdata;
                att_in_frame++;
                gap_len = 0;
                if (int'(nvm_addr) > max_addr) max_addr = int'(nvm_addr);
            end else begin
                cyc++;
                if (nvm_addr !== att_a || nvm_wdata !== att_d) stab_bad++;
            end
            if (!never_ack && cyc >= ack_delay) begin
                nvm_ack = 1'b1;
                nvm_err = (int'(nvm_addr) == err_addr) && (err_given < err_limit);
                if (nvm_err) err_given++;
                wr_cnt[nvm_addr]++;
                if (!nvm_err) begin
                    accepted++;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_extra got addr=%0d data=%h required no write", nvm_addr, nvm_wdata);
                    end else begin
                        e = sb.pop_front();
                        if (nvm_addr !== e.a || nvm_wdata !== e.d) begin
                            fails++;
                            $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                                     nvm_addr, nvm_wdata, e.a, e.d);
                        end
                    end
                end
            end else begin
                nvm_ack = 1'b0;
                nvm_err = 1'b0;
            end
        end
    end

    task automatic push_frame(input logic [FE*32-1:0] v);
        logic [31:0] s;
        wr_t w;
        s = MAGIC_W;
        w.a = 8'd0;
        w.d = MAGIC_W;
        sb.push_back(w);
        for (int i = 0; i < FE; i++) begin
            w.a = 8'(i + 1);
            w.d = v[32*i +: 32];
            s   = s + w.d;
            sb.push_back(w);
        end
        w.a = 8'(N - 1);
        w.d = s;
        sb.push_back(w);
    endtask

    task automatic clear_stats();
        att_in_frame = 0;
        gap_len = 0;
        gap_bad = 0;
        stab_bad = 0;
        accepted = 0;
        max_addr = 0;
        err_given = 0;
        att_len.delete();
        foreach (wr_cnt[i]) wr_cnt[i] = 0;
    endtask

    task automatic start_frame(input logic [FE*32-1:0] v);
        @(negedge clk);
        clear_stats();
        helper_data       = v;
        helper_data_valid = 1'b1;
    endtask

    // Returns cycles from the trigger edge to the edge that set stored/error.
    task automatic wait_done(input int budget, output int cycles, output logic busy_first);
        int n;
        n = 0;
        cycles = -1;
        busy_first = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) busy_first = busy;
            if (stored || error) begin
                cycles = n - 1;
                break;
            end
            if (n >= budget) begin
                tests++;
                fails++;
                $display("FAIL wait_done timed out after %0d cycles, required stored or error", n);
                break;
            end
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        helper_data_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [FE*32-1:0] rand_vec();
        logic [FE*32-1:0] v;
        for (int i = 0; i < FE; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        store_en = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({nvm_req, busy, stored, error} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got req/busy/stored/error=%b required 0000",
                     {nvm_req, busy, stored, error});
        end
        tests++;
        if (nvm_addr !== 8'd0 || nvm_wdata !== 32'd0 || fail_idx !== 5'd0) begin
            fails++;
            $display("FAIL reset_data got addr=%0d wdata=%h fail_idx=%0d required 0 0 0",
                     nvm_addr, nvm_wdata, fail_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_store();
        logic [FE*32-1:0] v;
        int cycles;
        logic bf;
        for (int i = 0; i < FE; i++) v[32*i +: 32] = 32'h1000_0000 + 32'(i);
        sb.delete();
        push_frame(v);
        store_en = 1'b1;
        start_frame(v);
        wait_done(200, cycles, bf);
        tests++;
        if (bf !== 1'b1) begin fails++; $display("FAIL clean_busy got %b required 1", bf); end
        tests++;
        if (cycles != 2 * N) begin fails++; $display("FAIL clean_latency got %0d required %0d", cycles, 2 * N); end
        tests++;
        if (stored !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL clean_status got stored=%b error=%b busy=%b required 1 0 0", stored, error, busy);
        end
        tests++;
        if (accepted != N || sb.size() != 0) begin
            fails++;
            $display("FAIL clean_count got %0d writes, %0d pending required %0d, 0", accepted, sb.size(), N);
        end
        end_frame();
    endtask

    task automatic test_wait_states();
        logic [FE*32-1:0] v;
        int cycles;
        logic bf;
        v = rand_vec();
        sb.delete();
        push_frame(v);
        ack_delay = 5;
        start_frame(v);
        wait_done(500, cycles, bf);
        ack_delay = 0;
        tests++;
        if (cycles != 7 * N) begin fails++; $display("FAIL wait_latency got %0d required %0d", cycles, 7 * N); end
        tests++;
        if (stab_bad != 0 || gap_bad != 0) begin
            fails++;
            $display("FAIL wait_handshake got unstable=%0d badgaps=%0d required 0 0", stab_bad, gap_bad);
        end
        tests++;
        if (accepted != N || att_in_frame != N || stored !== 1'b1) begin
            fails++;
            $display("FAIL wait_count got writes=%0d attempts=%0d stored=%b required %0d %0d 1",
                     accepted, att_in_frame, stored, N, N);
        end
        end_frame();
    endtask

    task automatic test_retry();
        logic [FE*32-1:0] v;
        int cycles;
        logic bf;
        v = rand_vec();
        sb.delete();
        push_frame(v);
        err_addr = 5;
        err_limit = 2;
        start_frame(v);
        wait_done(300, cycles, bf);
        tests++;
        if (wr_cnt[5] != 3 || accepted != N) begin
            fails++;
            $display("FAIL retry_writes got word5=%0d total=%0d required 3 %0d", wr_cnt[5], accepted, N);
        end
        tests++;
        if (stored !== 1'b1 || error !== 1'b0 || cycles != 2 * N + 4 || gap_bad != 0) begin
            fails++;
            $display("FAIL retry_status got stored=%b error=%b cycles=%0d badgaps=%0d required 1 0 %0d 0",
                     stored, error, cycles, 2 * N + 4, gap_bad);
        end
        end_frame();
    endtask

    task automatic test_retry_fail();
        logic [FE*32-1:0] v;
        int cycles;
        logic bf;
        v = rand_vec();
        sb.delete();
        push_frame(v);
        err_addr = 5;
        err_limit = 4;
        start_frame(v);
        wait_done(300, cycles, bf);
        tests++;
        if (error !== 1'b1 || stored !== 1'b0 || fail_idx !== 5'd5 || cycles != 18) begin
            fails++;
            $display("FAIL rfail_status got error=%b stored=%b fail_idx=%0d cycles=%0d required 1 0 5 18",
                     error, stored, fail_idx, cycles);
        end
        tests++;
        if (accepted != 5 || max_addr != 5 || wr_cnt[5] != 4) begin
            fails++;
            $display("FAIL rfail_writes got ok=%0d maxaddr=%0d word5=%0d required 5 5 4",
                     accepted, max_addr, wr_cnt[5]);
        end
        err_addr = -1;
        err_limit = 0;
        sb.delete();
        end_frame();
    endtask

    task automatic test_timeout();
        logic [FE*32-1:0] v;
        int cycles, bad;
        logic bf;
        v = rand_vec();
        sb.delete();
        never_ack = 1'b1;
        start_frame(v);
        wait_done(3000, cycles, bf);
        @(negedge clk);
        never_ack = 1'b0;
        bad = 0;
        foreach (att_len[i]) if (att_len[i] != 256) bad++;
        tests++;
        if (att_len.size() != 4 || bad != 0) begin
            fails++;
            $display("FAIL timeout_attempts got %0d attempts (%0d not 256 cycles) required 4 (0)",
                     att_len.size(), bad);
        end
        tests++;
        if (error !== 1'b1 || fail_idx !== 5'd0 || accepted != 0 || cycles != 1028) begin
            fails++;
            $display("FAIL timeout_status got error=%b fail_idx=%0d writes=%0d cycles=%0d required 1 0 0 1028",
                     error, fail_idx, accepted, cycles);
        end
        end_frame();
    endtask

    task automatic test_gating();
        logic [FE*32-1:0] va, vb;
        int cycles;
        logic bf;
        va = rand_vec();
        vb = ~va;
        sb.delete();
        store_en = 1'b0;
        start_frame(va);
        repeat (5) @(negedge clk);
        helper_data_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (att_in_frame != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gate_disarmed got attempts=%0d busy=%b required 0 0", att_in_frame, busy);
        end
        store_en = 1'b1;
        push_frame(va);
        start_frame(va);
        repeat (6) @(negedge clk);
        helper_data = vb;
        helper_data_valid = 1'b0;
        @(negedge clk);
        helper_data_valid = 1'b1;
        wait_done(200, cycles, bf);
        repeat (4) @(negedge clk);
        tests++;
        if (stored !== 1'b1 || accepted != N || sb.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gate_busy_edge got stored=%b writes=%0d pending=%0d busy=%b required 1 %0d 0 0",
                     stored, accepted, sb.size(), busy, N);
        end
        end_frame();
    endtask

    task automatic test_reset_mid();
        logic [FE*32-1:0] v;
        int cycles, n;
        logic bf;
        v = rand_vec();
        sb.delete();
        push_frame(v);
        ack_delay = 3;
        start_frame(v);
        n = 0;
        while (!(nvm_req && nvm_addr == 8'd10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL rmid_reach got no request at addr 10 required one within 500 cycles");
        end
        rst_n = 1'b0;
        helper_data_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({nvm_req, busy, stored, error} !== 4'b0000 || nvm_addr !== 8'd0 ||
            nvm_wdata !== 32'd0 || fail_idx !== 5'd0) begin
            fails++;
            $display("FAIL rmid_outputs got req/busy/stored/error=%b addr=%0d wdata=%h fail=%0d required all 0",
                     {nvm_req, busy, stored, error}, nvm_addr, nvm_wdata, fail_idx);
        end
        rst_n = 1'b1;
        ack_delay = 0;
        sb.delete();
        v = rand_vec();
        push_frame(v);
        start_frame(v);
        wait_done(200, cycles, bf);
        tests++;
        if (stored !== 1'b1 || accepted != N || cycles != 2 * N || sb.size() != 0) begin
            fails++;
            $display("FAIL rmid_restart got stored=%b writes=%0d cycles=%0d pending=%0d required 1 %0d %0d 0",
                     stored, accepted, cycles, sb.size(), N, 2 * N);
        end
        end_frame();
    endtask

    initial begin
        test_reset();
        test_clean_store();
        test_wait_states();
        test_retry();
        test_retry_fail();
        test_timeout();
        test_gating();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired, bench did not reach its summary");
        $fatal(1);
    end

endmodule
